// File: rtl/acc_pkg.sv
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared types and constants for the csa_accumulator block.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package acc_pkg;

    localparam int unsigned ACC_WIDTH = 16;
    localparam int unsigned ACC_CNT_W = 8;

    localparam logic [ACC_WIDTH-1:0] ACC_SAT_VAL = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

endpackage : acc_pkg

`default_nettype wire

// File: rtl/CSA_16bit.sv
// ============================================================================
//  Module      : CSA_16bit
//  Description : 16-bit carry-select adder built from 4-bit ripple blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module CSA_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] S,
    output logic        C_out
);

    localparam int unsigned BLK_W = 4;
    localparam int unsigned N_BLK = 16 / BLK_W;

    // Ripple-carry 4-bit add; returns {carry_out, sum}.
    function automatic logic [BLK_W:0] rca4(
        input logic [BLK_W-1:0] a,
        input logic [BLK_W-1:0] b,
        input logic             cin
    );
        logic [BLK_W:0]   c;
        logic [BLK_W-1:0] s;
        c[0] = cin;
        for (int i = 0; i < BLK_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        return {c[BLK_W], s};
    endfunction

    logic [N_BLK:0] w_carry;

    assign w_carry[0] = 1'b0;

    // Each block precomputes both carry-in outcomes; the incoming carry selects.
    for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
        logic [BLK_W:0] w_r0;
        logic [BLK_W:0] w_r1;

        assign w_r0 = rca4(A[gi*BLK_W +: BLK_W], B[gi*BLK_W +: BLK_W], 1'b0);
        assign w_r1 = rca4(A[gi*BLK_W +: BLK_W], B[gi*BLK_W +: BLK_W], 1'b1);

        assign S[gi*BLK_W +: BLK_W] = w_carry[gi] ? w_r1[BLK_W-1:0] : w_r0[BLK_W-1:0];
        assign w_carry[gi+1]        = w_carry[gi] ? w_r1[BLK_W]     : w_r0[BLK_W];
    end : g_blk

    assign C_out = w_carry[N_BLK];

endmodule : CSA_16bit

`default_nettype wire

// File: rtl/csa_accumulator.sv
// ============================================================================
//  Module      : csa_accumulator
//  Description : Streaming multi-operand reduction around CSA_16bit.
//                Optional saturation compiled in with ACC_SATURATE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module csa_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH,
    parameter int unsigned CNT_W = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_xfer;
    logic [WIDTH-1:0] w_acc_next;

    CSA_16bit u_adder (
        .A     (acc_q),
        .B     (in_data),
        .S     (w_sum),
        .C_out (w_cout)
    );

`ifdef ACC_SATURATE_EN
    // A carry-out means the true sum exceeded the range; clamp to full scale.
    assign w_acc_next = w_cout ? ACC_SAT_VAL : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    assign w_xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        remaining_d = remaining_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    remaining_d = len;
                    state_d     = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    acc_d       = w_acc_next;
                    ovf_d       = ovf_q | w_cout;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_sum = acc_q;
    assign out_ovf = ovf_q;
    assign busy    = (state_q != ST_IDLE);

endmodule : csa_accumulator

`default_nettype wire
